matrix_sobel: RTL and testbench
===============================

MATRIX_SOBEL -- requirements
Module: matrix_sobel

Interface
REQ-001 SHALL have parameter CNT_W, default 20, width of the per-frame edge counter (≥19 for 800x600).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-003 clk  input  1  pixel/system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 matrix_frame_vsync / matrix_frame_href / matrix_frame_clken  input  1 each  window stream sync and pixel-valid.
REQ-006 matrix_p11..matrix_p33  input  8 each  3x3 window; pX1 oldest column, p1Y top row.
REQ-007 threshold  input  8  edge threshold, sampled once per frame.
REQ-008 post_frame_vsync / post_frame_href / post_frame_clken  output  1 each  input syncs delayed 3 cycles.
REQ-009 post_img_data  output  8  filtered pixel, valid when post_frame_clken=1.
REQ-010 edge_cnt  output  CNT_W  edge-pixel count of last completed frame.
REQ-011 edge_cnt_valid  output  1  one-cycle pulse when edge_cnt updates.

Function
REQ-012 Stage 1 SHALL register gx_p=p13+2*p23+p33, gx_n=p11+2*p21+p31, gy_p=p31+2*p32+p33, gy_n=p11+2*p12+p13, each 10 bits unsigned, every clock.
REQ-013 Stage 2 SHALL register gx=|gx_p-gx_n|, gy=|gy_p-gy_n|, 10 bits each, no wrap.
REQ-014 Stage 3 SHALL compute mag=gx+gy (11 bits) and register post_img_data per REQ-026/027.
REQ-015 Datapath stages SHALL advance every clock; validity tracked only by delayed clken.
REQ-016 vsync, href, clken SHALL each pass through a 3-flop shift register; data and syncs aligned at output, latency exactly 3 cycles.
REQ-017 Frame start SHALL be the rising edge of matrix_frame_vsync (current=1, previous=0).
REQ-018 thr_lat SHALL load threshold at frame start and hold all frame; mid-frame threshold changes have no effect.
REQ-019 A pixel SHALL be an edge when post_frame_clken=1 and mag ≥ thr_lat (thr_lat as applied at stage 3).
REQ-020 Counter FSM states: IDLE (after reset), COUNT.
REQ-021 IDLE: on rising edge of post_frame_vsync -> COUNT, clear running count, no edge_cnt_valid pulse.
REQ-022 COUNT: each edge pixel increments running count; count SHALL saturate at all-ones, not wrap.
REQ-023 COUNT: on rising edge of post_frame_vsync, edge_cnt <= running count, edge_cnt_valid=1 for one cycle, running count <= 1 if an edge pixel occurs in that same cycle else 0.
REQ-024 edge_cnt SHALL hold its value between updates.

Reset
REQ-025 On rst_n=0, all pipeline registers, sync shift registers, thr_lat, running count, edge_cnt, edge_cnt_valid, post_* outputs SHALL be 0 immediately; FSM -> IDLE; reset mid-frame discards the partial frame.

Configuration
REQ-026 With macro SOBEL_BINARY_EN defined, post_img_data SHALL be 8'hFF when mag ≥ thr_lat, else 8'h00.
REQ-027 Without SOBEL_BINARY_EN, post_img_data SHALL be mag saturated to 255 (mag>255 -> 8'hFF); edge counting per REQ-019 unchanged.

Verification
REQ-028 Flat window all 50, threshold=10, clken=1 -> 3 cycles later post_img_data=0, post_frame_clken=1, both modes.
REQ-029 Left column 0, middle 100, right 200 -> gx=800, gy=0, mag=800 -> post_img_data=8'hFF both modes (thr 100).
REQ-030 Left column 10, middle 15, right 20 -> mag=40; binary mode thr 40 -> FF, thr 41 -> 00; non-binary -> 8'd40.
REQ-031 Threshold 40 latched at frame start, changed to 41 mid-frame -> mag-40 pixels still output FF until next vsync rise, then 00.
REQ-032 Reset, frame 1 vsync rise (no pulse), 5 edge pixels, frame 2 vsync rise -> edge_cnt=5, edge_cnt_valid high exactly 1 cycle, 3 cycles after input vsync rise.
REQ-033 rst_n low mid-frame after 3 edge pixels -> all outputs 0 next cycle; following first vsync rise yields no pulse; next frame count excludes the 3.

Source files
------------

// File: rtl/matrix_sobel.sv
// rtl/matrix_sobel.sv - 3x3 Sobel edge filter with per-frame edge-pixel counter
// Optional build macro: SOBEL_BINARY_EN (binary 8'hFF/8'h00 output instead of saturated magnitude)
module matrix_sobel #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             matrix_frame_vsync,
  input  logic             matrix_frame_href,
  input  logic             matrix_frame_clken,
  input  logic [7:0]       matrix_p11,
  input  logic [7:0]       matrix_p12,
  input  logic [7:0]       matrix_p13,
  input  logic [7:0]       matrix_p21,
  input  logic [7:0]       matrix_p22,
  input  logic [7:0]       matrix_p23,
  input  logic [7:0]       matrix_p31,
  input  logic [7:0]       matrix_p32,
  input  logic [7:0]       matrix_p33,
  input  logic [7:0]       threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic [7:0]       post_img_data,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             edge_cnt_valid
);

  typedef enum logic {IDLE, COUNT} state_t;

  logic [9:0]       gx_p, gx_n, gy_p, gy_n;
  logic [9:0]       gx, gy;
  logic [10:0]      mag;
  logic             mag_hit;
  logic             edge_hit;
  logic             vs_rise_next;
  logic [2:0]       vs_d, hs_d, ce_d;
  logic [7:0]       thr_lat;
  logic [CNT_W-1:0] run_cnt;
  state_t           state;

  // matrix_p22 does not contribute to the Sobel kernels
  logic unused_p22;
  assign unused_p22 = ^matrix_p22;

  // Stage-3 combinational view: magnitude, threshold hit and the edge flag that
  // becomes visible together with post_frame_clken on the next edge
  always_comb begin
    mag          = {1'b0, gx} + {1'b0, gy};
    mag_hit      = (mag >= {3'b000, thr_lat});
    edge_hit     = ce_d[1] & mag_hit;
    vs_rise_next = vs_d[1] & ~vs_d[2];
  end

  assign post_frame_vsync = vs_d[2];
  assign post_frame_href  = hs_d[2];
  assign post_frame_clken = ce_d[2];

  // Stage 1: weighted column/row sums of the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p <= '0;
      gx_n <= '0;
      gy_p <= '0;
      gy_n <= '0;
    end else begin
      gx_p <= {2'b00, matrix_p13} + {1'b0, matrix_p23, 1'b0} + {2'b00, matrix_p33};
      gx_n <= {2'b00, matrix_p11} + {1'b0, matrix_p21, 1'b0} + {2'b00, matrix_p31};
      gy_p <= {2'b00, matrix_p31} + {1'b0, matrix_p32, 1'b0} + {2'b00, matrix_p33};
      gy_n <= {2'b00, matrix_p11} + {1'b0, matrix_p12, 1'b0} + {2'b00, matrix_p13};
    end
  end

  // Stage 2: absolute gradients, subtracting the smaller from the larger so nothing wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx <= '0;
      gy <= '0;
    end else begin
      gx <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
      gy <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
    end
  end

  // Stage 3: output pixel, either binary edge map or saturated magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_data <= '0;
    end else begin
`ifdef SOBEL_BINARY_EN
      post_img_data <= mag_hit ? 8'hFF : 8'h00;
`else
      post_img_data <= (mag > 11'd255) ? 8'hFF : mag[7:0];
`endif
    end
  end

  // Sync delay lines keep vsync/href/clken aligned with the three datapath stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= '0;
      hs_d <= '0;
      ce_d <= '0;
    end else begin
      vs_d <= {vs_d[1:0], matrix_frame_vsync};
      hs_d <= {hs_d[1:0], matrix_frame_href};
      ce_d <= {ce_d[1:0], matrix_frame_clken};
    end
  end

  // Threshold is captured on the input vsync rise so mid-frame changes wait for the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_lat <= '0;
    end else if (matrix_frame_vsync && !vs_d[0]) begin
      thr_lat <= threshold;
    end
  end

  // Edge counter FSM; works on the output-aligned sync so counts match post_* pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      run_cnt        <= '0;
      edge_cnt       <= '0;
      edge_cnt_valid <= 1'b0;
    end else begin
      edge_cnt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (vs_rise_next) begin
            state   <= COUNT;
            run_cnt <= '0;
          end
        end
        COUNT: begin
          if (vs_rise_next) begin
            edge_cnt       <= run_cnt;
            edge_cnt_valid <= 1'b1;
            run_cnt        <= edge_hit ? CNT_W'(1) : '0;
          end else if (edge_hit && (run_cnt != {CNT_W{1'b1}})) begin
            run_cnt <= run_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_sobel.sv
// tb/tb_matrix_sobel.sv - directed-vector self-checking bench for matrix_sobel
module tb_matrix_sobel;

  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vsync, href, clken;
  logic [7:0]       p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [7:0]       threshold;
  logic             post_frame_vsync, post_frame_href, post_frame_clken;
  logic [7:0]       post_img_data;
  logic [CNT_W-1:0] edge_cnt;
  logic             edge_cnt_valid;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int pulse_base;

  matrix_sobel #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .matrix_frame_vsync (vsync),
    .matrix_frame_href  (href),
    .matrix_frame_clken (clken),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (p22),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33),
    .threshold          (threshold),
    .post_frame_vsync   (post_frame_vsync),
    .post_frame_href    (post_frame_href),
    .post_frame_clken   (post_frame_clken),
    .post_img_data      (post_img_data),
    .edge_cnt           (edge_cnt),
    .edge_cnt_valid     (edge_cnt_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (edge_cnt_valid) pulse_cnt++;

`ifdef SOBEL_BINARY_EN
  localparam logic [7:0] MAG40_THR40 = 8'hFF;
  localparam logic [7:0] MAG40_THR41 = 8'h00;
`else
  localparam logic [7:0] MAG40_THR40 = 8'd40;
  localparam logic [7:0] MAG40_THR41 = 8'd40;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cols(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
    p11 = l; p21 = l; p31 = l;
    p12 = m; p22 = m; p32 = m;
    p13 = r; p23 = r; p33 = r;
  endtask

  task automatic pix(input logic [7:0] l, input logic [7:0] m, input logic [7:0] r);
    set_cols(l, m, r);
    clken = 1'b1;
    href  = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    clken = 1'b0;
    href  = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame_start(input logic [7:0] thr);
    clken = 1'b0;
    href  = 1'b0;
    vsync = 1'b0;
    step();
    threshold = thr;
    vsync     = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b0; href = 1'b0; clken = 1'b0; threshold = 8'd0;
    set_cols(8'd0, 8'd0, 8'd0);
    step(); step();
    check("rst_data",  32'(post_img_data), 32'd0);
    check("rst_clken", 32'(post_frame_clken), 32'd0);
    check("rst_cnt",   32'(edge_cnt), 32'd0);
    check("rst_valid", 32'(edge_cnt_valid), 32'd0);
    rst_n = 1'b1;
    step();
    pulse_base = pulse_cnt;

    // Frame A: flat window, nothing is an edge; first vsync rise gives no pulse
    frame_start(8'd10);
    pix(8'd50, 8'd50, 8'd50); idle(2);
    check("flat_data",  32'(post_img_data), 32'd0);
    check("flat_clken", 32'(post_frame_clken), 32'd1);
    check("first_frame_no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);

    // Frame B: strong horizontal gradient, mag 800 saturates
    frame_start(8'd100);
    pix(8'd0, 8'd100, 8'd200); idle(2);
    check("grad800_data", 32'(post_img_data), 32'hFF);
    check("frameA_cnt",   32'(edge_cnt), 32'd0);

    // Frame C: mag 40 at threshold 40, then threshold changed mid-frame
    frame_start(8'd40);
    pix(8'd10, 8'd15, 8'd20); idle(2);
    check("mag40_thr40", 32'(post_img_data), 32'(MAG40_THR40));
    check("frameB_cnt",  32'(edge_cnt), 32'd1);
    check("pulses_AB",   32'(pulse_cnt - pulse_base), 32'd2);
    threshold = 8'd41;
    pix(8'd10, 8'd15, 8'd20); pix(8'd10, 8'd15, 8'd20); pix(8'd10, 8'd15, 8'd20); idle(2);
    check("midframe_thr", 32'(post_img_data), 32'(MAG40_THR40));

    // Frame D: threshold 41 now latched
    frame_start(8'd41);
    pix(8'd10, 8'd15, 8'd20); idle(2);
    check("mag40_thr41", 32'(post_img_data), 32'(MAG40_THR41));
    check("frameC_cnt",  32'(edge_cnt), 32'd4);

    // Reset, then 5 edges and exact pulse timing at the next vsync rise
    rst_n = 1'b0; vsync = 1'b0; step(); rst_n = 1'b1; step();
    pulse_base = pulse_cnt;
    frame_start(8'd20);
    pix(8'd10, 8'd15, 8'd20); pix(8'd50, 8'd50, 8'd50); pix(8'd10, 8'd15, 8'd20);
    pix(8'd10, 8'd15, 8'd20); pix(8'd50, 8'd50, 8'd50); pix(8'd10, 8'd15, 8'd20);
    pix(8'd10, 8'd15, 8'd20); idle(3);
    vsync = 1'b0; step(); step(); step();
    vsync = 1'b1;
    step(); check("valid_c1", 32'(edge_cnt_valid), 32'd0);
    step(); check("valid_c2", 32'(edge_cnt_valid), 32'd0);
    step(); check("valid_c3", 32'(edge_cnt_valid), 32'd1);
    check("five_cnt", 32'(edge_cnt), 32'd5);
    step(); check("valid_c4", 32'(edge_cnt_valid), 32'd0);
    check("cnt_hold", 32'(edge_cnt), 32'd5);
    check("one_pulse", 32'(pulse_cnt - pulse_base), 32'd1);

    // Reset mid-frame after 3 edges: partial frame discarded
    pix(8'd10, 8'd15, 8'd20); pix(8'd10, 8'd15, 8'd20); pix(8'd10, 8'd15, 8'd20); idle(3);
    rst_n = 1'b0; vsync = 1'b0;
    #1;
    check("mid_rst_vsync", 32'(post_frame_vsync), 32'd0);
    check("mid_rst_cnt",   32'(edge_cnt), 32'd0);
    check("mid_rst_data",  32'(post_img_data), 32'd0);
    step(); rst_n = 1'b1; step();
    pulse_base = pulse_cnt;
    frame_start(8'd20);
    idle(3);
    check("post_rst_no_pulse", 32'(pulse_cnt - pulse_base), 32'd0);
    pix(8'd10, 8'd15, 8'd20); pix(8'd10, 8'd15, 8'd20); idle(3);
    frame_start(8'd20);
    idle(3);
    check("post_rst_cnt",   32'(edge_cnt), 32'd2);
    check("post_rst_pulse", 32'(pulse_cnt - pulse_base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
